if_stage_prefetch: RTL
======================

Name: if_stage_prefetch

Overview:
Parametrised instruction-fetch stage that replaces the single PC register with a fetch unit and a prefetch queue. It fetches instructions from a synchronous instruction memory, buffers up to QUEUE_DEPTH entries, and hands them to ID through a valid/ready handshake. A taken branch flushes the queue and redirects fetch. It sits between the instruction memory and the IF/ID pipeline register.

Parameters:
ADDR_W, 32, PC and instruction-address width
INST_W, 32, instruction width
PC_STEP, 4, byte increment per sequential fetch
QUEUE_DEPTH, 4, prefetch queue entries; power of two, at least 2
RESET_PC, 0, fetch address after reset

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately
branch_taken  input  1  redirect request from EX
branch_addr  input  ADDR_W  redirect target
imem_req  output  1  read request to the instruction memory this cycle
imem_addr  output  ADDR_W  read address
imem_rdata  input  INST_W  read data, valid in the cycle after imem_req
out_valid  output  1  queue head is valid
out_ready  input  1  ID accepts the head; the old freeze is equivalent to out_ready=0
instruction  output  INST_W  head instruction
pc  output  ADDR_W  head fetch address + PC_STEP
q_count  output  clog2(QUEUE_DEPTH)+1  queue occupancy

Behaviour:
- Reset (rst=0): fetch_pc=RESET_PC, queue empty, rd/wr pointers=0, inflight=0, imem_req=0, out_valid=0, q_count=0. Outputs hold these values while rst=0. A reset in mid-operation discards any in-flight response.
- Issue: imem_req=1 when branch_taken=0 and q_count + inflight + (pop this cycle ? -1 : 0) < QUEUE_DEPTH. imem_addr=fetch_pc. On issue, fetch_pc <= fetch_pc + PC_STEP (wraps modulo 2^ADDR_W), and inflight <= 1. Otherwise inflight <= 0.
- Response: in the cycle after an issue (inflight=1), push {imem_rdata, issued_addr + PC_STEP} at wr_ptr. The pointer wraps modulo QUEUE_DEPTH.
- Pop: when out_valid and out_ready, rd_ptr advances with wrap-around. instruction and pc always reflect the head entry and are combinational from the queue.
- Push and pop in the same cycle: q_count is unchanged. The issue rule guarantees that a push never occurs when the queue is full. An assertion fires if it does.
- Empty queue: out_valid=0. instruction and pc are don't-care, and the bench must not check them.
- Redirect: branch_taken=1 in cycle N has priority over everything:
  - the queue is cleared (q_count=0, pointers reset to 0);
  - any pop in that cycle is ignored;
  - the response arriving in cycle N is dropped;
  - imem_req=0 in cycle N;
  - fetch_pc <= branch_addr.
  The first target request issues in N+1, its data is pushed at the end of N+2, and out_valid=1 from N+3.
- Back-to-back branches: the last one wins, and each one restarts the N+3 latency.
- Steady state with out_ready=1: one instruction per cycle after a 2-cycle startup (first out_valid in cycle 2 after rst deasserts).

Optional Feature:
IF_PERF_CNT_EN:
- Defined: adds the outputs perf_fetched[31:0] (count of issued requests), perf_flushed[31:0] (count of queue entries plus in-flight responses discarded by branches), and perf_stall[31:0] (cycles with out_valid=1 and out_ready=0). All counters reset to 0 on rst=0 and wrap at 2^32.
- Undefined: these ports and registers do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, out_ready=1, memory word[i]=i → imem_addr 0,4,8,…; out_valid from cycle 2; instruction 0,1,2,… with pc 4,8,12,….
- out_ready=0 for 10 cycles, QUEUE_DEPTH=4 → q_count saturates at 4; imem_req=0 once 4 entries are queued or in flight; no entry lost or duplicated after out_ready returns to 1.
- branch_taken=1 with branch_addr=0x100 while q_count=3 and a response is in flight → q_count=0 next cycle; imem_addr=0x100 in N+1; first instruction=word[0x40], pc=0x104, out_valid in N+3; dropped entries never appear.
- branch_taken in two consecutive cycles (0x200 then 0x300) → only 0x300-stream instructions are delivered.
- rst pulsed low mid-stream with 2 entries queued → out_valid=0 and q_count=0 immediately; fetch restarts at RESET_PC.
- With IF_PERF_CNT_EN: 8 fetches, one branch flushing 3 queued entries plus 1 in flight, and 5 stall cycles → perf_fetched=8, perf_flushed=4, perf_stall=5.

Source files
------------

// File: rtl/if_stage_prefetch_if.sv
// Fetch-stage bundle: branch redirect, instruction-memory request/response and the ID-side valid/ready head.
// master = fetch stage view, slave = environment (EX/imem/ID) view.
interface if_stage_prefetch_if #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned INST_W      = 32,
    parameter int unsigned QUEUE_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic              branch_taken;
    logic [ADDR_W-1:0] branch_addr;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] instruction;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  q_count;

    modport master (
        input  branch_taken, branch_addr, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, instruction, pc, q_count
    );

    modport slave (
        output branch_taken, branch_addr, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, instruction, pc, q_count
    );
endinterface

// File: rtl/if_stage_prefetch.sv
// Instruction fetch unit with a QUEUE_DEPTH-entry prefetch queue; optional IF_PERF_CNT_EN adds perf counters.
// Latency: 2 cycles from issue to out_valid; branch redirect delivers its target 3 cycles after branch_taken.
// Backpressure: out_ready=0 holds the head; requests stop once queued plus in-flight entries fill the queue.
module if_stage_prefetch #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       INST_W      = 32,
    parameter int unsigned       PC_STEP     = 4,
    parameter int unsigned       QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_prefetch_if.master bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
    output logic [31:0] perf_stall
`endif
);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] issued_addr_q, issued_addr_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [INST_W-1:0] inst_q [QUEUE_DEPTH];
    logic [INST_W-1:0] inst_d [QUEUE_DEPTH];
    logic [ADDR_W-1:0] pcq_q  [QUEUE_DEPTH];
    logic [ADDR_W-1:0] pcq_d  [QUEUE_DEPTH];

    logic              out_valid;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    demand;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && bus.out_ready && !bus.branch_taken;
    assign push      = inflight_q && !bus.branch_taken;

    // Slots already promised: queued entries plus the outstanding response, minus the slot freed by this pop.
    assign demand = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign issue  = rst && !bus.branch_taken && (demand < (CNT_W+1)'(QUEUE_DEPTH));

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.out_valid   = out_valid;
    assign bus.instruction = inst_q[rd_ptr_q];
    assign bus.pc          = pcq_q[rd_ptr_q];
    assign bus.q_count     = count_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        issued_addr_d = issued_addr_q;
        inflight_d    = 1'b0;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        inst_d        = inst_q;
        pcq_d         = pcq_q;

        if (bus.branch_taken) begin
            // Redirect drops the queue, any pop, and the response landing this cycle.
            fetch_pc_d = bus.branch_addr;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + ADDR_W'(PC_STEP);
                issued_addr_d = fetch_pc_q;
                inflight_d    = 1'b1;
            end
            if (push) begin
                inst_d[wr_ptr_q] = bus.imem_rdata;
                pcq_d[wr_ptr_q]  = issued_addr_q + ADDR_W'(PC_STEP);
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            issued_addr_q <= '0;
            inflight_q    <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                inst_q[i] <= '0;
                pcq_q[i]  <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            issued_addr_q <= issued_addr_d;
            inflight_q    <= inflight_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inst_q        <= inst_d;
            pcq_q         <= pcq_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic [31:0] perf_stall_q,   perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(issue);
        perf_flushed_d = perf_flushed_q;
        perf_stall_d   = perf_stall_q + 32'(out_valid && !bus.out_ready);
        if (bus.branch_taken) begin
            perf_flushed_d = perf_flushed_q + 32'(count_q) + 32'(inflight_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
    assign perf_stall   = perf_stall_q;
`endif

    // The issue rule reserves a slot for every outstanding response, so a push never meets a full queue.
    assert property (@(posedge clk) disable iff (!rst) push |-> (count_q < CNT_W'(QUEUE_DEPTH)));

endmodule
